// File: rtl/truth_table_sequencer.sv
//==============================================================================
// Module      : truth_table_sequencer
// Description : Sweeps abc through 0..7 with a req/ack handshake and captures
//               the datapath result of each combination into an 8-bit table.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module truth_table_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] abc,
    output logic       req,
    input  logic       ack,
    input  logic       f_in,
    output logic [7:0] table_out,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    logic [1:0] state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [7:0] wait_q,  wait_d;
    logic [7:0] table_q, table_d;
    logic [3:0] ones_q,  ones_d;
    logic       err_q,   err_d;
    logic [7:0] w_wait_inc;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        wait_d     = wait_q;
        table_d    = table_q;
        ones_d     = ones_q;
        err_d      = err_q;
        w_wait_inc = wait_q + 8'd1;

        case (state_q)
            c_idle: begin
                if (start) begin
                    state_d = c_req;
                    index_d = 3'd0;
                    wait_d  = 8'd0;
                    table_d = 8'd0;
                    ones_d  = 4'd0;
                    err_d   = 1'b0;
                end
            end
            c_req: begin
                if (ack) begin
                    table_d[index_q] = f_in;
                    ones_d           = ones_q + {3'd0, f_in};
                    // The last entry leaves directly so the index never wraps.
                    state_d          = (index_q == 3'd7) ? c_done : c_gap;
                end else begin
                    wait_d = w_wait_inc;
                    if (w_wait_inc == c_max_wait) begin
                        err_d   = 1'b1;
                        state_d = c_done;
                    end
                end
            end
            c_gap: begin
                index_d = index_q + 3'd1;
                wait_d  = 8'd0;
                state_d = c_req;
            end
            c_done: begin
                state_d = c_idle;
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_idle;
            index_q <= 3'd0;
            wait_q  <= 8'd0;
            table_q <= 8'd0;
            ones_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            wait_q  <= wait_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode straight from state so reset clears them at once.
    assign abc       = index_q;
    assign req       = (state_q == c_req);
    assign busy      = (state_q != c_idle);
    assign done      = (state_q == c_done);
    assign table_out = table_q;
    assign ones      = ones_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15, meaning: maximum cycles REQ waits for ack before timeout (range 1-255).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-005 Port abc  output  3  current input combination to the evaluated datapath; abc[2]=a, abc[1]=b, abc[0]=c.
REQ-006 Port req  output  1  abc is valid; datapath result requested.
REQ-007 Port ack  input  1  datapath result f_in valid this cycle.
REQ-008 Port f_in  input  1  datapath result for the current abc.
REQ-009 Port table_out  output  8  captured truth table; bit i = result for abc==i.
REQ-010 Port ones  output  4  count of 1 entries in table_out (0-8).
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port done  output  1  one-cycle pulse at sweep end (normal or timeout).
REQ-013 Port err  output  1  timeout flag; sticky until next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, GAP, DONE.
REQ-015 In IDLE with start=1, the FSM SHALL move to REQ and SHALL set index=0, table_out=0, ones=0, err=0, wait counter=0.
REQ-016 In IDLE with start=0, the FSM SHALL stay in IDLE with table_out, ones, err held.
REQ-017 The abc output SHALL equal the 3-bit index in all states; req SHALL be 1 only in REQ.
REQ-018 In REQ with ack=1: table_out[index] SHALL be written with f_in, ones SHALL increment by f_in, and next state SHALL be GAP if index<7, else DONE.
REQ-019 In REQ with ack=0: the wait counter SHALL increment; when it reaches MAX_WAIT, err SHALL be set and next state SHALL be DONE, with no write of that entry.
REQ-020 In GAP, index SHALL increment by 1, the wait counter SHALL clear, and next state SHALL be REQ (req low exactly one cycle between entries).
REQ-021 In DONE, done SHALL be 1 for that cycle only; next state SHALL be IDLE.
REQ-022 The start input SHALL be ignored in REQ, GAP and DONE; a start in DONE SHALL NOT begin a sweep.
REQ-023 With ack tied high, a sweep SHALL take 16 cycles: REQ/GAP x7, REQ, DONE; done is asserted in the 16th cycle after the start-sampling edge.
REQ-024 The ones output SHALL never wrap; it is bounded at 8 by construction (4-bit width).
REQ-025 The index SHALL never wrap during a sweep; the index==7 capture SHALL exit to DONE.
REQ-026 On timeout, table_out and ones SHALL keep entries captured before the timeout; the remaining bits SHALL stay 0.

Reset
REQ-027 On rst=1, the block SHALL immediately (asynchronously) enter IDLE with index=0, abc=0, req=0, busy=0, done=0, err=0, table_out=0, ones=0, wait counter=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; a new start is required after release.
REQ-029 After release, the first rising edge SHALL evaluate the IDLE transition normally.

Verification
REQ-030 Datapath f=(~a|b)&(b|~c), ack tied 1, pulse start -> done in 16th cycle, table_out=8'hCD, ones=5, err=0.
REQ-031 Same datapath, ack asserted 3 cycles after each req rise -> table_out=8'hCD, ones=5, each abc held stable while req=1.
REQ-032 MAX_WAIT=15, ack stuck 0 -> done after 15 wait cycles in REQ for abc=0, err=1, table_out=0, ones=0; err clears on next start.
REQ-033 Start held high through whole sweep -> exactly one sweep, then a second sweep begins from the IDLE cycle after DONE.
REQ-034 rst asserted while abc=5 in REQ -> outputs zero in same cycle, no done pulse, busy=0.
REQ-035 Constant-1 datapath -> table_out=8'hFF, ones=8; constant-0 datapath -> table_out=8'h00, ones=0.
